// File: rtl/he_top.sv
// Hamming SEC encoder: K-bit data in, {parity, data} codeword out through a
// two-stage valid/ready pipeline with one-shot single-bit error injection.
module he_top #(
  parameter  int K = 8,
  localparam int M = (K == 1)    ? 2  :
                     (K <= 4)    ? 3  :
                     (K <= 11)   ? 4  :
                     (K <= 26)   ? 5  :
                     (K <= 57)   ? 6  :
                     (K <= 120)  ? 7  :
                     (K <= 247)  ? 8  :
                     (K <= 502)  ? 9  :
                     (K <= 1013) ? 10 : 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] din,
  input  logic         din_vld,
  output logic         din_rdy,
  output logic [K+M-1:0] cout,
  output logic         cout_vld,
  input  logic         cout_rdy,
  input  logic         inj_req,
  input  logic [M-1:0] inj_pos,
  output logic         inj_pend
);

  logic           s1_vld;
  logic [K-1:0]   s1_data;
  logic           s2_vld;
  logic           s1_adv;
  logic [M-1:0]   inj_pos_q;
  logic [M-1:0]   parity;
  logic [K+M-1:0] inj_mask;

  // Hamming position of data bit d: the (d+1)-th positive non-power-of-two.
  function automatic logic [M-1:0] data_pos(input int d);
    int cnt;
    data_pos = '0;
    cnt = 0;
    for (int x = 3; x < 2**M; x++) begin
      if ((x & (x - 1)) != 0) begin
        if (cnt == d) data_pos = M'(x);
        cnt++;
      end
    end
  endfunction

  assign s1_adv   = s1_vld & (~s2_vld | cout_rdy);
  assign din_rdy  = ~s1_vld | s1_adv;
  assign cout_vld = s2_vld;

  always_comb begin
    logic [M-1:0] pos;
    pos    = '0;
    parity = '0;
    for (int d = 0; d < K; d++) begin
      pos = data_pos(d);
      for (int j = 0; j < M; j++) begin
        if (pos[j]) parity[j] = parity[j] ^ s1_data[d];
      end
    end
  end

  // Out-of-range positions shift the one off the top, leaving an empty mask.
  assign inj_mask = inj_pend ? ((K+M)'(1) << inj_pos_q) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else if (din_vld && din_rdy) begin
      s1_vld  <= 1'b1;
      s1_data <= din;
    end else if (s1_adv) begin
      s1_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld <= 1'b0;
      cout   <= '0;
    end else if (s1_adv) begin
      s2_vld <= 1'b1;
      cout   <= {parity, s1_data} ^ inj_mask;
    end else if (cout_rdy) begin
      s2_vld <= 1'b0;
    end
  end

  // A new request always wins, so a request coinciding with a load re-arms
  // for the following word while the load consumes the old one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inj_pend  <= 1'b0;
      inj_pos_q <= '0;
    end else if (inj_req) begin
      inj_pend  <= 1'b1;
      inj_pos_q <= inj_pos;
    end else if (s1_adv) begin
      inj_pend  <= 1'b0;
    end
  end

endmodule

// File: doc/he_top.md
Name: he_top

Overview:
- Hamming SEC encoder. It is the transmit-side counterpart to the team's Hamming decoder: it takes K-bit data words and emits K+M-bit codewords in the layout the decoder consumes.
- Codeword layout: data in bits [K-1:0], parity in bits [K+M-1:K].
- Two-stage registered pipeline with valid/ready backpressure on both sides.
- A one-shot single-bit error-injection facility lets benches and bring-up exercise the decoder's correction path.

Parameters:
- K, 8, data width in bits (1..2036).
- M, localparam, parity width: K==1→2, ≤4→3, ≤11→4, ≤26→5, ≤57→6, ≤120→7, ≤247→8, ≤502→9, ≤1013→10, else 11. Guarantees K+M ≤ 2^M−1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- din  input  K  data word.
- din_vld  input  1  din valid.
- din_rdy  output  1  encoder can accept din.
- cout  output  K+M  codeword.
- cout_vld  output  1  cout valid.
- cout_rdy  input  1  downstream accepts cout.
- inj_req  input  1  single-cycle request to corrupt one upcoming codeword.
- inj_pos  input  M  bit index to flip; sampled with inj_req.
- inj_pend  output  1  an injection is armed and not yet applied.

Behaviour:
- Reset: rst asynchronous, active-low; clock clk. While rst=0 all state clears:
  - s1_vld=0, s2_vld=0 (cout_vld=0), cout=0, inj_pend=0, inj_pos register=0.
  - din_rdy=1 once reset deasserts (pipeline empty).
- Position mapping:
  - Data bit d maps to Hamming position pos(d) = the (d+1)-th positive integer that is not a power of two (d0→3, d1→5, d2→6, d3→7, d4→9, …).
  - Parity bit j = XOR of all din[d] with bit j of pos(d) set.
  - This matches the decoder's syndrome-to-bit mapping exactly.
- Stage 1 (input register):
  - Captures din when din_vld & din_rdy.
  - din_rdy = ~s1_vld | s1_adv, where s1_adv = s1_vld & (~s2_vld | cout_rdy).
  - din_rdy is combinational from cout_rdy; no combinational path from din_vld to din_rdy.
- Parity: combinational from the stage-1 data register only.
- Stage 2 (output register):
  - On s1_adv, loads cout = {parity, s1_data} XOR inj_mask.
  - s2_vld set on load; cleared when cout_vld & cout_rdy with no simultaneous load.
- Latency: word accepted at edge E appears on cout with cout_vld=1 after edge E+1 when unstalled.
- Throughput: one word per cycle with cout_rdy held high.
- Stall: while cout_vld=1 and cout_rdy=0, cout and cout_vld hold stable, and stage 1 holds. Data is never dropped or duplicated.
- Injection:
  - inj_req=1 arms inj_pend=1 and latches inj_pos.
  - The next stage-2 load while inj_pend=1 uses inj_mask = (1 << inj_pos), then clears inj_pend. Otherwise inj_mask = 0.
  - inj_pos ≥ K+M: no bit flipped, but the pending request is still consumed.
  - inj_req while inj_pend=1: the request is re-armed with the new inj_pos; still only one flip.
  - inj_req in the same cycle as a stage-2 load: the load uses the old pending state; the new request arms for the following word.
- Simultaneous push and pop: fully supported on both stages.
- Reset mid-stream: in-flight words are discarded and any pending injection is cancelled.

Test Plan:
- K=8, reset, then din=8'h01, din_vld=1 for one cycle, cout_rdy=1 → cout_vld rises after edge E+1, cout=12'h301.
- Stream 8'h00, 8'hFF, 8'h80 back-to-back, cout_rdy=1 → 12'h000, 12'h3FF, 12'hC80 on consecutive cycles; din_rdy stays 1.
- Backpressure: drive 4 words, cout_rdy=0 for 5 cycles then 1 → din_rdy falls after 2 words accepted, cout stable while stalled, all 4 words delivered in order, none dropped.
- Injection: inj_req=1, inj_pos=4'd2, then din=8'h01 → cout=12'h305, inj_pend=1→0 on load; next word 8'h01 → 12'h301. inj_pos=4'd13 → unmodified 12'h301, inj_pend cleared.
- Loopback with the decoder: random din plus single injection at every inj_pos 0..11 → decoder dout equals din for every case.
- Assert rst low with 2 words in flight and inj_pend=1 → cout_vld=0, cout=0, inj_pend=0 immediately; no stale word emitted after release.
